demux_1to4_stream: RTL and testbench
====================================

// Module: demux_1to4_stream
// PURPOSE
//   Registered 1-to-4 stream demultiplexer. It routes each input word to one of
//   four output channels, chosen by a 2-bit select sent with the word.
//   Each channel has a one-entry holding register with valid/ready flow control.
//   Counts words delivered per channel. Inverse of the 4:1 select path: it fans
//   out one producer to four consumers.
// PARAMETERS
//   DATA_W  8  width of each data word
//   CNT_W   8  width of each per-channel delivered-word counter (wraps)
// PORTS
//   clk        in   1          rising-edge clock
//   rst        in   1          asynchronous reset, active-high
//   in_data    in   DATA_W     input word
//   in_sel     in   2          target channel index (0..3) for in_data
//   in_valid   in   1          in_data/in_sel valid
//   in_ready   out  1          block can take the word (combinational)
//   out_data   out  4*DATA_W   channel k word at [k*DATA_W +: DATA_W]
//   out_valid  out  4          bit k: channel k holds a word
//   out_ready  in   4          bit k: consumer k takes its word this cycle
//   deliv_cnt  out  4*CNT_W    channel k count at [k*CNT_W +: CNT_W]
// BEHAVIOUR
//   Reset (rst=1, async, any time): out_valid=0, out_data=0, deliv_cnt=0.
//     Takes effect at once, with no clock edge. Words held at that moment are
//     discarded. Outputs stay at reset values while rst=1.
//   Channel state per k: EMPTY (out_valid[k]=0) or FULL (out_valid[k]=1).
//   in_ready = !out_valid[in_sel] | out_ready[in_sel].
//     This is a function of the selected channel only. Other channels never
//     stall the input.
//   accept = in_valid & in_ready. On that clk edge, channel in_sel loads
//     in_data and sets out_valid. Latency is 1 cycle from accept to out_valid.
//   drain_k = out_valid[k] & out_ready[k]. On that edge deliv_cnt[k] += 1.
//     The counter wraps from 2^CNT_W-1 to 0, with no saturation or flag.
//   Channel k transitions on each clk edge:
//     EMPTY, accept to k          -> FULL, load data
//     FULL,  drain_k, no accept k -> EMPTY (out_data keeps last value)
//     FULL,  drain_k and accept k -> FULL, load new data (back-to-back, no bubble)
//     FULL,  !drain_k             -> FULL, out_data held stable
//   While out_valid[k]=1 and out_ready[k]=0, out_data[k] must not change.
//   At most one channel loads per cycle. Any number of channels may drain in
//   the same cycle, each independently.
//   in_sel and in_data are sampled only when in_valid=1. When in_valid=0 they
//   are don't-care, and in_ready still follows in_sel.
//   in_sel is always legal (all 2-bit values map to a channel). No X
//   propagation is allowed from an unused in_sel.
//   Throughput is 1 word/cycle if consumers keep out_ready high.
// TESTING
//   1 Reset: assert rst mid-cycle with ch1 FULL. Required: out_valid=0000 and
//     deliv_cnt all 0 before the next clk edge.
//   2 Route: send 0xA0,0xA1,0xA2,0xA3 with sel 0,1,2,3 and all out_ready=0.
//     Required: out_valid=1111 after 4 edges and ch k holds 0xAk.
//     A 5th word with sel=2 sees in_ready=0.
//   3 Back-to-back: sel=3, out_ready[3]=1, stream 0x10..0x17 for 8 cycles.
//     Required: in_ready stays 1 and ch3 shows 0x10..0x17 on consecutive
//     cycles. deliv_cnt[3]=8 one edge after the last word drains.
//   4 Stall hold: ch0 FULL with 0x5A, out_ready[0]=0 for 5 cycles while words
//     arrive for ch1. Required: ch0 data stays 0x5A, ch1 keeps accepting,
//     deliv_cnt[0] unchanged.
//   5 Wrap: CNT_W=8, drain 256 words on ch2. Required: deliv_cnt[2]=0 with no
//     other channel count changed. Words 255 and 256 give 255 then 0.
//   6 Simultaneous: in the same cycle drain ch0 and ch1 and accept a word for
//     ch1. Required: ch0 EMPTY, ch1 FULL with the new word, deliv_cnt[0] and
//     deliv_cnt[1] each +1.

Source files
------------

// File: rtl/demux_1to4_stream.sv
// Registered 1-to-4 stream demultiplexer: routes each input word to the channel named by in_sel.
// Each channel has a one-entry valid/ready holding register and a wrapping delivered-word counter.
module demux_1to4_stream #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     in_data,
  input  logic [1:0]            in_sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [4*DATA_W-1:0]   out_data,
  output logic [3:0]            out_valid,
  input  logic [3:0]            out_ready,
  output logic [4*CNT_W-1:0]    deliv_cnt
);

  logic [3:0]        valid_q, valid_d;
  logic [DATA_W-1:0] data_q [4];
  logic [DATA_W-1:0] data_d [4];
  logic [CNT_W-1:0]  cnt_q  [4];
  logic [CNT_W-1:0]  cnt_d  [4];
  logic              accept;

  // Only the selected channel can stall the producer.
  assign in_ready = ~valid_q[in_sel] | out_ready[in_sel];
  assign accept   = in_valid & in_ready;

  always_comb begin
    valid_d = valid_q;
    for (int k = 0; k < 4; k++) begin
      data_d[k] = data_q[k];
      cnt_d[k]  = cnt_q[k];
      if (valid_q[k] && out_ready[k]) begin
        cnt_d[k]   = cnt_q[k] + CNT_W'(1);
        valid_d[k] = 1'b0;
      end
      // A load in the same cycle as a drain refills the slot with no bubble.
      if (accept && (in_sel == 2'(k))) begin
        valid_d[k] = 1'b1;
        data_d[k]  = in_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int k = 0; k < 4; k++) begin
        data_q[k] <= '0;
        cnt_q[k]  <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int k = 0; k < 4; k++) begin
        data_q[k] <= data_d[k];
        cnt_q[k]  <= cnt_d[k];
      end
    end
  end

  always_comb begin
    out_valid = valid_q;
    out_data  = '0;
    deliv_cnt = '0;
    for (int k = 0; k < 4; k++) begin
      out_data[k*DATA_W +: DATA_W] = data_q[k];
      deliv_cnt[k*CNT_W +: CNT_W]  = cnt_q[k];
    end
  end

endmodule

// File: tb/tb_demux_1to4_stream.sv
// Bench for demux_1to4_stream: a per-channel occupancy model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_demux_1to4_stream;

  logic        clk;
  logic        rst;
  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] deliv_cnt;

  int checks = 0;
  int errors = 0;

  demux_1to4_stream #(.DATA_W(8), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .deliv_cnt (deliv_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: each channel is a slot holding zero or one word, the last word seen, and a
  // count of words handed to its consumer modulo 256.
  int         m_occ [4];
  logic [7:0] m_word [4];
  logic [7:0] m_cnt [4];

  function automatic logic m_ready();
    return (m_occ[in_sel] == 0) || out_ready[in_sel];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        m_occ[k]  <= 0;
        m_word[k] <= 8'h00;
        m_cnt[k]  <= 8'h00;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (m_occ[k] == 1 && out_ready[k]) m_cnt[k] <= m_cnt[k] + 8'd1;
        if (in_valid && m_ready() && in_sel == 2'(k)) begin
          m_occ[k]  <= 1;
          m_word[k] <= in_data;
        end else if (m_occ[k] == 1 && out_ready[k]) begin
          m_occ[k] <= 0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("model out_valid[%0d]", k), 32'(out_valid[k]), 32'(m_occ[k] == 1));
      chk($sformatf("model out_data[%0d]", k), 32'(out_data[k*8 +: 8]), 32'(m_word[k]));
      chk($sformatf("model deliv_cnt[%0d]", k), 32'(deliv_cnt[k*8 +: 8]), 32'(m_cnt[k]));
    end
    chk("model in_ready", 32'(in_ready), 32'(m_ready()));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 4'b0000;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish, required finish");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    in_data   = 8'h00;
    in_sel    = 2'd0;
    in_valid  = 1'b0;
    out_ready = 4'b0000;
    do_reset();
    chk("reset out_valid", 32'(out_valid), 32'h0);
    chk("reset deliv_cnt", deliv_cnt, 32'h0);

    // Mid-cycle async reset with ch1 full and a nonzero count.
    in_sel = 2'd1; in_data = 8'h77; in_valid = 1'b1; step();
    in_valid = 1'b0; out_ready = 4'b0010; step();
    out_ready = 4'b0000; in_data = 8'h78; in_valid = 1'b1; step();
    in_valid = 1'b0;
    chk("pre-reset ch1 valid", 32'(out_valid), 32'h2);
    chk("pre-reset cnt1", 32'(deliv_cnt[15:8]), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("async reset out_valid", 32'(out_valid), 32'h0);
    chk("async reset deliv_cnt", deliv_cnt, 32'h0);
    chk("async reset out_data", out_data, 32'h0);
    step();
    rst = 1'b0;

    // Route one word to each channel with all consumers stalled.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      in_sel = 2'(k); in_data = 8'hA0 + 8'(k); in_valid = 1'b1; step();
    end
    chk("route out_valid", 32'(out_valid), 32'hF);
    chk("route data", out_data, 32'hA3A2A1A0);
    in_sel = 2'd2; in_data = 8'hEE; #1;
    chk("route 5th in_ready", 32'(in_ready), 32'h0);
    step();
    in_valid = 1'b0;
    chk("route ch2 unchanged", 32'(out_data[23:16]), 32'hA2);

    // Back-to-back stream on ch3.
    do_reset();
    in_sel = 2'd3; out_ready = 4'b1000;
    for (int i = 0; i < 8; i++) begin
      in_data = 8'h10 + 8'(i); in_valid = 1'b1; #1;
      chk("b2b in_ready", 32'(in_ready), 32'h1);
      step();
      chk("b2b ch3 data", 32'(out_data[31:24]), 32'(8'h10 + 8'(i)));
    end
    in_valid = 1'b0; step();
    chk("b2b cnt3", 32'(deliv_cnt[31:24]), 32'h8);
    chk("b2b ch3 empty", 32'(out_valid), 32'h0);

    // Stalled ch0 holds while ch1 keeps streaming.
    do_reset();
    in_sel = 2'd0; in_data = 8'h5A; in_valid = 1'b1; step();
    out_ready = 4'b0010; in_sel = 2'd1;
    for (int i = 0; i < 5; i++) begin
      in_data = 8'h60 + 8'(i); #1;
      chk("stall in_ready", 32'(in_ready), 32'h1);
      step();
      chk("stall ch0 data", 32'(out_data[7:0]), 32'h5A);
      chk("stall ch1 data", 32'(out_data[15:8]), 32'(8'h60 + 8'(i)));
    end
    in_valid = 1'b0;
    chk("stall cnt0", 32'(deliv_cnt[7:0]), 32'h0);
    chk("stall cnt1", 32'(deliv_cnt[15:8]), 32'h4);

    // Counter wrap on ch2 after 256 deliveries.
    do_reset();
    in_sel = 2'd2; out_ready = 4'b0100; in_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      in_data = 8'(i); step();
    end
    in_valid = 1'b0;
    chk("wrap cnt2 at 255", 32'(deliv_cnt[23:16]), 32'hFF);
    step();
    chk("wrap cnt2 at 256", 32'(deliv_cnt[23:16]), 32'h0);
    chk("wrap other counts", deliv_cnt & 32'hFF00FFFF, 32'h0);

    // Drain ch0 and ch1 while loading ch1 in the same cycle.
    do_reset();
    in_sel = 2'd0; in_data = 8'h11; in_valid = 1'b1; step();
    in_sel = 2'd1; in_data = 8'h22; step();
    out_ready = 4'b0011; in_data = 8'h33; step();
    in_valid = 1'b0; out_ready = 4'b0000;
    chk("simul out_valid", 32'(out_valid), 32'h2);
    chk("simul ch1 data", 32'(out_data[15:8]), 32'h33);
    chk("simul ch0 keeps last", 32'(out_data[7:0]), 32'h11);
    chk("simul counts", deliv_cnt, 32'h00000101);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
